// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan controller:
// hex-to-segment table, segment bit positions and output polarity helper.
package ssd_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Active-high segments, {a,b,c,d,e,f,g}, indexed by nibble value
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    function automatic logic [7:0] polarize(
        input logic [7:0] v,
        input logic       active_low
    );
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational nibble to active-high seven-segment pattern.
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/ssd_scan_controller.sv
// Frame-synchronous, double-buffered N-digit seven-segment scanner with
// per-digit enable/dp, leading-zero suppression, blanking and PWM dimming.
module ssd_scan_controller
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int PRESCALE     = 18,
    parameter int BLANK_CYCLES = 256,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    ClkPort,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              cathode,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [PRESCALE-1:0]     pcnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_en;
    logic                    sh_lz;
    logic [3:0]              sh_bright;

    logic [NUM_DIGITS-1:0]   supp;
    logic [3:0]              nib;
    logic [6:0]              seg;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   an_nx;
    logic [6:0]              seg_nx;
    logic                    dp_nx;
    logic [7:0]              an_p;
    logic [7:0]              seg_p;

    // Held low during reset so the counters' 0/0 state does not flag a frame
    assign frame_start = !reset && (pcnt == '0) && (idx == '0);

    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
            idx  <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
            if (&pcnt)
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_en     <= '0;
            sh_lz     <= 1'b0;
            sh_bright <= '0;
        end else if (frame_start) begin
            sh_digits <= digits_in;
            sh_dp     <= dp_in;
            sh_en     <= digit_en;
            sh_lz     <= lz_blank;
            sh_bright <= brightness;
        end
    end

    // Walk from the most significant digit down; hb = all higher digits blank
    always_comb begin : lz_chain
        logic hb;
        hb   = 1'b1;
        supp = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (i > 0)
                supp[i] = sh_lz && hb && (sh_digits[4*i +: 4] == 4'h0);
            hb = hb && (!sh_en[i] || (sh_digits[4*i +: 4] == 4'h0));
        end
    end

    assign nib = sh_digits[4*int'(idx) +: 4];

    ssd_hex_decoder u_dec (
        .nibble (nib),
        .seg    (seg)
    );

    always_comb begin
        lit = sh_en[idx]
           && (pcnt >= PRESCALE'(BLANK_CYCLES))
           && (pcnt[PRESCALE-1 -: 4] <= sh_bright);
        an_nx  = lit ? (NUM_DIGITS'(1) << idx) : '0;
        seg_nx = (lit && !supp[idx]) ? seg : '0;
        dp_nx  = lit && sh_dp[idx];
        an_p   = polarize(8'(an_nx), POL);
        seg_p  = polarize({dp_nx, seg_nx}, POL);
    end

    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            anode   <= {NUM_DIGITS{POL}};
            cathode <= {7{POL}};
            dp      <= POL;
        end else begin
            anode   <= an_p[NUM_DIGITS-1:0];
            cathode <= seg_p[6:0];
            dp      <= seg_p[7];
        end
    end

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Directed bench for ssd_scan_controller (4 digits, 32-cycle slots).
module tb_ssd_scan_controller;

    logic        ClkPort = 1'b0;
    logic        reset;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        lz_blank;
    logic [3:0]  brightness;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic        dp;
    logic        frame_start;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 ClkPort = ~ClkPort;

    ssd_scan_controller #(
        .NUM_DIGITS   (4),
        .PRESCALE     (5),
        .BLANK_CYCLES (2),
        .ACTIVE_LOW   (1)
    ) dut (
        .ClkPort     (ClkPort),
        .reset       (reset),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .lz_blank    (lz_blank),
        .brightness  (brightness),
        .anode       (anode),
        .cathode     (cathode),
        .dp          (dp),
        .frame_start (frame_start)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d got %0h exp %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] an,
                           input logic [6:0] ca, input logic d);
        chk({tag, ".anode"}, 32'(anode), 32'(an));
        chk({tag, ".cathode"}, 32'(cathode), 32'(ca));
        chk({tag, ".dp"}, 32'(dp), 32'(d));
    endtask

    task automatic adv_to(input int target);
        while (cyc < target) begin
            @(negedge ClkPort);
            cyc++;
        end
    endtask

    initial begin
        reset      = 1'b1;
        digits_in  = 16'h1234;
        dp_in      = 4'b0000;
        digit_en   = 4'b1111;
        lz_blank   = 1'b0;
        brightness = 4'd15;
        repeat (3) @(negedge ClkPort);
        chk_out("rst", 4'b1111, 7'b1111111, 1'b1);
        chk("rst.fs", 32'(frame_start), 32'd0);

        reset = 1'b0;
        cyc   = 0;
        #1;
        chk("fs0", 32'(frame_start), 32'd1);
        adv_to(1);
        chk("fs1", 32'(frame_start), 32'd0);
        adv_to(2);
        chk_out("blank_p1", 4'b1111, 7'b1111111, 1'b1);
        adv_to(3);
        chk_out("d0_p2", 4'b1110, 7'b1001100, 1'b1);
        adv_to(32);
        chk_out("d0_p31", 4'b1110, 7'b1001100, 1'b1);
        adv_to(34);
        chk_out("d1_p1", 4'b1111, 7'b1111111, 1'b1);
        adv_to(35);
        chk_out("d1_p2", 4'b1101, 7'b0000110, 1'b1);
        adv_to(99);
        chk_out("d3_p2", 4'b0111, 7'b1001111, 1'b1);
        adv_to(127);
        chk("fs127", 32'(frame_start), 32'd0);
        adv_to(128);
        chk("fs128", 32'(frame_start), 32'd1);

        adv_to(150);
        digits_in = 16'hABCD;
        adv_to(163);
        chk_out("tear_d1", 4'b1101, 7'b0000110, 1'b1);
        adv_to(256);
        chk("fs256", 32'(frame_start), 32'd1);
        adv_to(259);
        chk_out("D", 4'b1110, 7'b1000010, 1'b1);
        adv_to(291);
        chk_out("C", 4'b1101, 7'b0110001, 1'b1);
        adv_to(323);
        chk_out("B", 4'b1011, 7'b1100000, 1'b1);
        adv_to(355);
        chk_out("A", 4'b0111, 7'b0001000, 1'b1);

        adv_to(360);
        digits_in = 16'h0070;
        lz_blank  = 1'b1;
        dp_in     = 4'b1000;
        adv_to(387);
        chk_out("lz_d0", 4'b1110, 7'b0000001, 1'b1);
        adv_to(419);
        chk_out("lz_d1", 4'b1101, 7'b0001111, 1'b1);
        adv_to(451);
        chk_out("lz_d2", 4'b1011, 7'b1111111, 1'b1);
        adv_to(483);
        chk_out("lz_d3", 4'b0111, 7'b1111111, 1'b0);

        adv_to(490);
        digits_in  = 16'h1234;
        lz_blank   = 1'b0;
        dp_in      = 4'b0000;
        brightness = 4'd0;
        adv_to(515);
        chk_out("br0_p2", 4'b1111, 7'b1111111, 1'b1);
        adv_to(520);
        chk_out("br0_p7", 4'b1111, 7'b1111111, 1'b1);
        adv_to(544);
        chk_out("br0_p31", 4'b1111, 7'b1111111, 1'b1);

        adv_to(600);
        brightness = 4'd7;
        adv_to(643);
        chk_out("br7_p2", 4'b1110, 7'b1001100, 1'b1);
        adv_to(656);
        chk_out("br7_p15", 4'b1110, 7'b1001100, 1'b1);
        adv_to(657);
        chk_out("br7_p16", 4'b1111, 7'b1111111, 1'b1);

        adv_to(700);
        brightness = 4'd15;
        digit_en   = 4'b0101;
        adv_to(771);
        chk_out("en_d0", 4'b1110, 7'b1001100, 1'b1);
        adv_to(803);
        chk_out("en_d1", 4'b1111, 7'b1111111, 1'b1);
        adv_to(835);
        chk_out("en_d2", 4'b1011, 7'b0010010, 1'b1);
        adv_to(867);
        chk_out("en_d3", 4'b1111, 7'b1111111, 1'b1);

        adv_to(977);
        chk_out("pre_rst", 4'b1011, 7'b0010010, 1'b1);
        reset = 1'b1;
        #1;
        chk_out("mid_rst", 4'b1111, 7'b1111111, 1'b1);
        chk("mid_rst.fs", 32'(frame_start), 32'd0);
        repeat (2) @(negedge ClkPort);
        reset = 1'b0;
        cyc   = 0;
        #1;
        chk("rel.fs0", 32'(frame_start), 32'd1);
        adv_to(1);
        chk("rel.fs1", 32'(frame_start), 32'd0);
        adv_to(3);
        chk_out("rel_d0", 4'b1110, 7'b1001100, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ssd_scan_controller.md
# ssd_scan_controller

Parametrised, time-multiplexed seven-segment display driver for an N-digit common-anode display. Replaces the fixed 4-digit scan logic in the top level with a frame-synchronous, double-buffered scanner that adds per-digit enables, per-digit decimal points, leading-zero suppression, anti-ghosting blanking and 16-level brightness PWM. It sits in the top level between game/debug status registers and the board's An*/Ca..Cg/Dp pins.

## Interface
- NUM_DIGITS, 8, digits scanned (1..8); index width = max(1, clog2(NUM_DIGITS))
- PRESCALE, 18, digit slot length = 2^PRESCALE clocks (>= 5)
- BLANK_CYCLES, 256, anode-off dead time at start of each slot (< 2^(PRESCALE-4))
- ACTIVE_LOW, 1, 1 = anodes, segments and dp driven active-low
- ClkPort  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high
- digits_in  in  4*NUM_DIGITS  hex nibble per digit; [3:0] = digit 0 (rightmost)
- dp_in  in  NUM_DIGITS  1 = light decimal point of digit i
- digit_en  in  NUM_DIGITS  1 = digit i may light; 0 = anode held inactive
- lz_blank  in  1  1 = suppress leading zeros
- brightness  in  4  0 = 1/16 duty, 15 = full duty
- anode  out  NUM_DIGITS  digit select
- cathode  out  7  segments {a,b,c,d,e,f,g}
- dp  out  1  decimal point segment
- frame_start  out  1  high for the one cycle in which both counters are zero

## Operation
- Prescaler pcnt (PRESCALE bits) increments every clock, wraps to 0; on wrap, digit index idx increments, wrapping NUM_DIGITS-1 -> 0.
- Capture: on the clock edge ending a cycle with pcnt==0 and idx==0 (frame_start high), digits_in, dp_in, digit_en, lz_blank register into display shadow registers. Inputs are ignored at all other times; no mid-frame tearing.
- Decode (from shadow registers only): hex 0-F standard table (0 = abcdef, 1 = bc, ..., F = aefg).
- Leading-zero suppression when lz_blank=1: digit i (i>0) has segments blanked if its nibble is 0 and every higher digit is either disabled or also zero; digit 0 never suppressed. Suppression blanks segments only; dp still follows dp_in.
- Anode for idx active iff digit_en[idx] and pcnt >= BLANK_CYCLES and pcnt[PRESCALE-1:PRESCALE-4] <= brightness. All other anodes inactive. Exactly zero or one anode active at any time.
- Cathode/dp show decoded pattern of digit idx whenever its anode is active; all segments off otherwise.
- Polarity: ACTIVE_LOW=1 inverts anode, cathode, dp (lit = 0).

## Timing
- Reset (async, immediate, also mid-frame): pcnt=0, idx=0, shadow regs=0, anode all inactive, cathode all off, dp off, frame_start=0.
- First cycle after reset release: counters 0/0, frame_start=1, capture at its closing edge.
- anode/cathode/dp are registered: they reflect pcnt/idx/shadow state of the previous cycle (1-cycle latency). frame_start is combinational from registered counters.
- Slot = 2^PRESCALE cycles; frame = NUM_DIGITS * 2^PRESCALE cycles; frame_start period equals frame.
- Input change -> visible at earliest at next frame boundary, latest one frame + 1 cycle later.
- brightness change takes effect at next capture (shadowed with the rest).
- NUM_DIGITS=1: idx stays 0; every slot is a frame.

## Structure
- Shared package ssd_pkg: 16-entry hex-to-segment table, segment bit order constants, polarity helper.
- One sub-module: ssd_hex_decoder (combinational nibble -> 7-bit active-high segments).
- Leading-zero chain, counters, PWM compare and output registers live in ssd_scan_controller.

## Test plan
Use NUM_DIGITS=4, PRESCALE=5, BLANK_CYCLES=2, ACTIVE_LOW=1.
- Reset released, digits_in=16'h1234, brightness=15, all enabled -> frame_start at cycle 0 and every 128 cycles; digit 0 anode=4'b1110 low for pcnt 2..31 (lagged 1), cathode=7'b1001100 ("4"); digit 3 shows "1" (7'b1001111).
- Change digits_in to 16'hABCD at mid-frame -> outputs unchanged until next frame_start; then "D","C","B","A" appear.
- digits_in=16'h0070, lz_blank=1 -> digits 3 and 2 segments off, digit 1 shows "7", digit 0 shows "0"; dp_in=4'b1000 -> dp=0 during digit 3 slot despite suppression.
- brightness=0 -> anode active only pcnt 2..1 window i.e. never beyond top-nibble 0 (pcnt 2..1 empty with PRESCALE=5: check active for pcnt==2..1 -> none); repeat brightness=7 -> active pcnt 2..15 each slot.
- digit_en=4'b0101 -> anodes 1 and 3 never active; digits 0,2 normal.
- Assert reset at pcnt=17, idx=2 -> same cycle anode=4'b1111, cathode=7'b1111111, dp=1, frame_start=0; restart from 0/0 on release.
